aha_code_loader: RTL and testbench
==================================

Name: aha_code_loader

Overview:
- AHB-Lite master that copies a little-endian byte stream into the 64 KB code region before the Cortex-M3 leaves reset.
- Assembles four bytes into one 32-bit word and writes it to HADDR = BASE + 4*n.
- Sits directly upstream of the code-region slave. It is arbitrated onto the code bus in place of the CPU while CPU_RELEASE is low.
- Reports completion or bus error and gates CPU release.

Parameters:
- CNT_W, 14, width of the word count; 2^14 words = 64 KB.
- BASE_ADDR, 32'h0000_0000, word-aligned start address of the load image.

Ports:
- HCLK  input  1  clock
- HRESETn  input  1  reset, asynchronous, active-low
- LD_START  input  1  one-cycle start pulse
- LD_LEN  input  CNT_W+1  number of words to load, sampled on LD_START
- LD_VALID  input  1  byte valid
- LD_DATA  input  8  byte data
- LD_READY  output  1  byte accepted when LD_VALID & LD_READY
- HTRANS  output  2  AHB transfer type
- HADDR  output  32  AHB address
- HWRITE  output  1  always 1 when HTRANS != IDLE
- HSIZE  output  3  fixed 3'b010 (word)
- HWDATA  output  32  write data
- HREADY  input  1  AHB ready from the code region
- HRESP  input  2  AHB response; 2'b01 = ERROR
- LD_BUSY  output  1  high in FILL, ADDR and DATA
- LD_DONE  output  1  sticky, set when all words are written
- LD_ERR  output  1  sticky, set on an ERROR response
- CPU_RELEASE  output  1  high only while LD_DONE is high

Behaviour:
- Reset values:
  - state IDLE
  - HTRANS=2'b00, HADDR=BASE_ADDR, HWDATA=0, HWRITE=0
  - LD_READY=0, LD_BUSY=0, LD_DONE=0, LD_ERR=0, CPU_RELEASE=0
  - internal byte index=0, word count=0
- States: IDLE, FILL, ADDR, DATA, DONE, ERR.
- IDLE/DONE/ERR:
  - LD_START loads len=LD_LEN, clears word count, byte index, LD_DONE and LD_ERR, and sets HADDR=BASE_ADDR.
  - If LD_LEN==0, go to DONE. Otherwise go to FILL.
  - LD_START is ignored in FILL, ADDR and DATA.
- FILL:
  - LD_READY=1.
  - Each accepted byte goes into word[8*idx +: 8], little-endian, and idx increments.
  - When the 4th byte is accepted, go to ADDR on the next cycle and wrap idx to 0.
  - LD_VALID low stalls without penalty.
- ADDR:
  - Drive HTRANS=2'b10 (NONSEQ), HWRITE=1, HSIZE=3'b010, HADDR=current address.
  - Hold all of these stable while HREADY=0.
  - When HREADY=1, go to DATA.
- DATA:
  - HTRANS=2'b00. HWDATA holds the assembled word until the data phase completes.
  - On HREADY=1 and HRESP==2'b01: go to ERR, set LD_ERR, leave HADDR at the failing address.
  - On HREADY=1 and HRESP==2'b00: count+1 and HADDR+4.
    - If count+1==len, go to DONE and set LD_DONE.
    - Otherwise go to FILL.
  - HREADY=0 extends the data phase. HRESP is ignored while HREADY=0; the first cycle of a two-cycle error is not acted on.
  - A single-cycle ERROR (HREADY=1, HRESP=01) is legal and must be handled. Out-of-range accesses to the code region return this.
- Address arithmetic:
  - 32-bit, wraps modulo 2^32.
  - HADDR[1:0] is always 2'b00.
- Timing:
  - Minimum 6 cycles per word with continuous LD_VALID: 4 FILL, 1 ADDR, 1 DATA with zero wait states.
  - No address/data pipelining: one outstanding transfer at most.
- CPU_RELEASE = LD_DONE, registered. It never glitches and falls only on a new LD_START or reset.
- Reset asserted mid-transfer returns immediately to reset values. The partially written word is abandoned.

Test Plan:
- LD_START with LD_LEN=2, bytes 11,22,33,44,55,66,77,88, HREADY=1 -> write 32'h44332211 @0x0, then 32'h88776655 @0x4. LD_DONE=1 and CPU_RELEASE=1 after the 2nd data phase; 12 cycles from first byte to LD_DONE.
- Same as above with HREADY held low for 3 cycles in ADDR and 2 in DATA -> HTRANS/HADDR stable during the ADDR waits, HWDATA stable during the DATA waits, data written correctly, no extra transfer issued.
- Slave returns HRESP=01 for 2 cycles (HREADY 0 then 1) on word 1 -> LD_ERR=1, LD_DONE=0, CPU_RELEASE=0, HADDR=0x4, no further HTRANS!=IDLE.
- Single-cycle ERROR (HREADY=1, HRESP=01) on a write to 0x0001_0000 -> ERR state; a later LD_START clears LD_ERR and the reload succeeds.
- LD_LEN=0 -> DONE the next cycle, no AHB transfer issued, LD_READY stays 0.
- HRESETn pulsed low during DATA of word 3 of 8 -> all outputs return to reset values asynchronously. A new LD_START of 8 words rewrites from BASE_ADDR.

Source files
------------

// File: rtl/aha_code_loader_if.sv
// -----------------------------------------------------------------------------
// aha_code_loader_if
// AHB-Lite write-path bundle between the code loader (master) and the
// code-region slave.
//   HTRANS  [1:0]  transfer type (IDLE 2'b00 / NONSEQ 2'b10)  master -> slave
//   HADDR   [31:0] byte address, always word aligned         master -> slave
//   HWRITE         write strobe for the address phase        master -> slave
//   HSIZE   [2:0]  transfer size, word                       master -> slave
//   HWDATA  [31:0] write data for the data phase             master -> slave
//   HREADY         phase completion / wait-state insertion   slave  -> master
//   HRESP   [1:0]  2'b00 OKAY, 2'b01 ERROR                   slave  -> master
// -----------------------------------------------------------------------------
interface aha_code_loader_if;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [1:0]  HRESP;

  modport master (
    output HTRANS, HADDR, HWRITE, HSIZE, HWDATA,
    input  HREADY, HRESP
  );

  modport slave (
    input  HTRANS, HADDR, HWRITE, HSIZE, HWDATA,
    output HREADY, HRESP
  );
endinterface

// File: rtl/aha_code_loader.sv
// -----------------------------------------------------------------------------
// aha_code_loader
// AHB-Lite master that streams a little-endian byte image into the code
// region while the Cortex-M3 is held in reset. Four bytes form one word,
// written to BASE_ADDR + 4*n. One transfer is outstanding at most (no
// address/data pipelining). Completion releases the CPU; a bus ERROR stops
// the load and keeps the CPU held.
//
// Ports
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   LD_START             one-cycle start pulse (ignored while busy)
//   LD_LEN   [CNT_W:0]   words to load, sampled with LD_START
//   LD_VALID/LD_DATA     byte stream in, LD_READY back-pressure
//   ahb                  AHB-Lite master bundle (aha_code_loader_if.master)
//   LD_BUSY              high in FILL, ADDR and DATA
//   LD_DONE              sticky, all words written
//   LD_ERR               sticky, ERROR response seen
//   CPU_RELEASE          registered copy of LD_DONE
//   o_dbg_state [2:0]    current FSM state (state_t encoding)
//
// Handshake: a byte moves on a rising HCLK edge where LD_VALID && LD_READY
// are both high; LD_VALID may drop at any time and simply stalls the fill.
// On the AHB side an address or data phase completes only on an edge with
// HREADY high; HRESP is only looked at on that edge.
// -----------------------------------------------------------------------------
module aha_code_loader #(
  parameter int          CNT_W     = 14,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             LD_START,
  input  logic [CNT_W:0]   LD_LEN,
  input  logic             LD_VALID,
  input  logic [7:0]       LD_DATA,
  output logic             LD_READY,
  aha_code_loader_if.master ahb,
  output logic             LD_BUSY,
  output logic             LD_DONE,
  output logic             LD_ERR,
  output logic             CPU_RELEASE,
  output logic [2:0]       o_dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};

  state_t          r_state;
  state_t          w_state_nxt;

  logic [1:0]      r_idx;     // byte lane of the next accepted byte
  logic [23:0]     r_word;    // lower three bytes of the word being built
  logic [31:0]     r_hwdata;  // completed word, stable through ADDR and DATA
  logic [29:0]     r_waddr;   // word address; HADDR[1:0] is always zero
  logic [CNT_W:0]  r_len;
  logic [CNT_W:0]  r_cnt;
  logic            r_done;
  logic            r_err;
  logic            r_release;

  logic            w_start;
  logic            w_accept;
  logic            w_beat_ok;
  logic            w_beat_err;
  logic            w_last;
  logic [CNT_W:0]  w_cnt_inc;

  assign w_cnt_inc = r_cnt + CNT_ONE;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state, event strobes and state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_beat_ok   = 1'b0;
    w_beat_err  = 1'b0;
    w_last      = 1'b0;
    LD_READY    = 1'b0;
    LD_BUSY     = 1'b0;
    ahb.HTRANS  = 2'b00;
    ahb.HWRITE  = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (LD_START) begin
          w_start     = 1'b1;
          w_state_nxt = (LD_LEN == '0) ? ST_DONE : ST_FILL;
        end
      end

      ST_FILL: begin
        LD_READY = 1'b1;
        LD_BUSY  = 1'b1;
        if (LD_VALID) begin
          w_accept = 1'b1;
          if (r_idx == 2'd3) begin
            w_state_nxt = ST_ADDR;
          end
        end
      end

      ST_ADDR: begin
        LD_BUSY    = 1'b1;
        ahb.HTRANS = 2'b10;
        ahb.HWRITE = 1'b1;
        if (ahb.HREADY) begin
          w_state_nxt = ST_DATA;
        end
      end

      ST_DATA: begin
        LD_BUSY = 1'b1;
        if (ahb.HREADY) begin
          // Only OKAY counts as success; any other response aborts the load.
          if (ahb.HRESP != 2'b00) begin
            w_beat_err  = 1'b1;
            w_state_nxt = ST_ERR;
          end else begin
            w_beat_ok   = 1'b1;
            w_last      = (w_cnt_inc == r_len);
            w_state_nxt = w_last ? ST_DONE : ST_FILL;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: byte assembly, address/count tracking, sticky status
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_idx     <= 2'd0;
      r_word    <= 24'd0;
      r_hwdata  <= 32'd0;
      r_waddr   <= BASE_ADDR[31:2];
      r_len     <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_release <= 1'b0;
    end else begin
      if (w_start) begin
        r_len     <= LD_LEN;
        r_cnt     <= '0;
        r_idx     <= 2'd0;
        r_err     <= 1'b0;
        r_waddr   <= BASE_ADDR[31:2];
        // A zero-length load is complete immediately. CPU_RELEASE is a
        // separate flop loaded with the same value so it changes on the
        // same edge as LD_DONE and never leads or trails it.
        r_done    <= (LD_LEN == '0);
        r_release <= (LD_LEN == '0);
      end

      if (w_accept) begin
        r_idx <= r_idx + 2'd1;
        case (r_idx)
          2'd0:    r_word[7:0]   <= LD_DATA;
          2'd1:    r_word[15:8]  <= LD_DATA;
          2'd2:    r_word[23:16] <= LD_DATA;
          default: r_hwdata      <= {LD_DATA, r_word};
        endcase
      end

      if (w_beat_ok) begin
        r_cnt   <= w_cnt_inc;
        r_waddr <= r_waddr + 30'd1;
        if (w_last) begin
          r_done    <= 1'b1;
          r_release <= 1'b1;
        end
      end

      // HADDR is left on the failing address.
      if (w_beat_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign ahb.HADDR  = {r_waddr, 2'b00};
  assign ahb.HSIZE  = 3'b010;
  assign ahb.HWDATA = r_hwdata;

  assign LD_DONE     = r_done;
  assign LD_ERR      = r_err;
  assign CPU_RELEASE = r_release;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_aha_code_loader.sv
// -----------------------------------------------------------------------------
// tb_aha_code_loader
// Directed bench for aha_code_loader. The model turns each byte image into the
// list of (address, word) writes the loader must issue; a negedge monitor pops
// that list on every accepted address phase and checks protocol rules every
// cycle. A small AHB slave inserts wait states and ERROR responses.
// -----------------------------------------------------------------------------
module tb_aha_code_loader;

  localparam int          CNT_W = 14;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [2:0]  S_IDLE = 3'd0, S_DATA = 3'd3, S_DONE = 3'd4, S_ERR = 3'd5;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic             HCLK = 1'b0;
  logic             HRESETn;
  logic             LD_START;
  logic [CNT_W:0]   LD_LEN;
  logic             LD_VALID;
  logic [7:0]       LD_DATA;
  logic             LD_READY, LD_BUSY, LD_DONE, LD_ERR, CPU_RELEASE;
  logic [2:0]       dbg_state;

  aha_code_loader_if bus ();

  always #5 HCLK = ~HCLK;

  aha_code_loader #(.CNT_W(CNT_W), .BASE_ADDR(BASE)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .LD_START    (LD_START),
    .LD_LEN      (LD_LEN),
    .LD_VALID    (LD_VALID),
    .LD_DATA     (LD_DATA),
    .LD_READY    (LD_READY),
    .ahb         (bus),
    .LD_BUSY     (LD_BUSY),
    .LD_DONE     (LD_DONE),
    .LD_ERR      (LD_ERR),
    .CPU_RELEASE (CPU_RELEASE),
    .o_dbg_state (dbg_state)
  );

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_xfer   = 0;
  logic [63:0] exp_q[$];              // {address, data} in issue order
  logic [31:0] mem [logic [31:0]];    // words the slave accepted with OKAY
  logic [7:0]  stim[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: word n of the image is bytes 4n..4n+3, little-endian, at BASE+4n.
  task automatic model(input int len);
    for (int n = 0; n < len; n++) begin
      logic [31:0] w;
      w = {stim[4*n+3], stim[4*n+2], stim[4*n+1], stim[4*n]};
      exp_q.push_back({BASE + 32'(4 * n), w});
    end
  endtask

  // ---------------------------------------------------------------------------
  // AHB slave: programmable wait states and ERROR injection
  // ---------------------------------------------------------------------------
  int          cfg_aw = 0, cfg_dw = 0;
  bit          cfg_err_en = 0, cfg_err_two = 0;
  logic [31:0] cfg_err_addr = 32'h0;

  initial begin
    bit          s_addr_pending, s_dphase, s_err;
    int          s_aw_left, s_dw_left;
    logic [31:0] s_addr;
    s_addr_pending = 0; s_dphase = 0; s_err = 0; s_aw_left = 0; s_dw_left = 0; s_addr = 0;
    bus.HREADY = 1'b1;
    bus.HRESP  = 2'b00;
    forever begin
      @(posedge HCLK); #1;
      if (!HRESETn) begin
        s_addr_pending = 0; s_dphase = 0;
        bus.HREADY = 1'b1; bus.HRESP = 2'b00;
      end else begin
        if (s_dphase && bus.HREADY) s_dphase = 0;
        if (s_addr_pending && bus.HREADY) begin
          s_addr_pending = 0;
          s_dphase  = 1;
          s_dw_left = cfg_dw;
          s_err     = cfg_err_en && (s_addr == cfg_err_addr);
          if (s_err && cfg_err_two && s_dw_left == 0) s_dw_left = 1;
        end
        if (s_dphase) begin
          if (s_dw_left > 0) begin
            bus.HREADY = 1'b0;
            bus.HRESP  = (s_err && cfg_err_two && s_dw_left == 1) ? 2'b01 : 2'b00;
            s_dw_left--;
          end else begin
            bus.HREADY = 1'b1;
            bus.HRESP  = s_err ? 2'b01 : 2'b00;
          end
        end else if (bus.HTRANS == 2'b10) begin
          if (!s_addr_pending) begin
            s_addr_pending = 1; s_aw_left = cfg_aw; s_addr = bus.HADDR;
          end
          if (s_aw_left > 0) begin bus.HREADY = 1'b0; s_aw_left--; end
          else bus.HREADY = 1'b1;
          bus.HRESP = 2'b00;
        end else begin
          bus.HREADY = 1'b1; bus.HRESP = 2'b00;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / compare process
  // ---------------------------------------------------------------------------
  bit          m_dphase = 0, m_dfirst = 0, m_has_exp = 0, m_addr_wait = 0;
  logic [31:0] m_addr, m_wdata, m_exp_data, m_held_addr;
  logic [1:0]  m_held_trans;

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      m_dphase = 0; m_addr_wait = 0;
    end else begin
      check("release_eq_done", CPU_RELEASE, LD_DONE);
      if (m_dphase) begin
        if (m_dfirst) begin m_wdata = bus.HWDATA; m_dfirst = 0; end
        else check("hwdata_stable", bus.HWDATA, m_wdata);
        if (bus.HREADY) begin
          if (m_has_exp) check("hwdata", bus.HWDATA, m_exp_data);
          if (bus.HRESP == 2'b00) mem[m_addr] = bus.HWDATA;
          n_xfer++;
          m_dphase = 0;
        end
      end
      if (bus.HTRANS == 2'b10) begin
        check("hwrite", bus.HWRITE, 1'b1);
        check("hsize", bus.HSIZE, 3'b010);
        check("haddr_align", bus.HADDR[1:0], 2'b00);
        if (m_addr_wait) begin
          check("haddr_stable", bus.HADDR, m_held_addr);
          check("htrans_stable", bus.HTRANS, m_held_trans);
        end
        if (bus.HREADY) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++; m_has_exp = 0;
            $display("FAIL unexpected_transfer: HADDR %h issued, no write expected", bus.HADDR);
          end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("haddr", bus.HADDR, e[63:32]);
            m_exp_data = e[31:0]; m_has_exp = 1;
          end
          m_dphase = 1; m_dfirst = 1; m_addr = bus.HADDR; m_addr_wait = 0;
        end else begin
          m_addr_wait = 1; m_held_addr = bus.HADDR; m_held_trans = bus.HTRANS;
        end
      end else begin
        if (m_addr_wait) check("htrans_held_in_wait", bus.HTRANS, 2'b10);
        m_addr_wait = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (entered and left at posedge+1)
  // ---------------------------------------------------------------------------
  int t_first, t_done;

  task automatic do_start(input int len);
    @(posedge HCLK); #1;
    LD_START = 1'b1; LD_LEN = (CNT_W+1)'(len);
    @(posedge HCLK); #1;
    LD_START = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit first);
    int t = 0;
    LD_VALID = 1'b1; LD_DATA = b;
    @(negedge HCLK);
    while (!LD_READY && t < 200) begin @(negedge HCLK); t++; end
    n_checks++;
    if (!LD_READY) begin
      n_fail++;
      $display("FAIL byte_accept: LD_READY low for %0d cycles, byte %h", t, b);
    end
    if (first) t_first = cyc;
    @(posedge HCLK); #1;
    LD_VALID = 1'b0;
  endtask

  task automatic send_bytes(input int n, input int gap_every);
    for (int i = 0; i < n; i++) begin
      if (gap_every > 0 && i % gap_every == gap_every - 1) begin @(posedge HCLK); #1; end
      send_byte(stim[i], i == 0);
    end
  endtask

  task automatic wait_end(input int budget);
    int t = 0;
    @(negedge HCLK);
    while (!(LD_DONE || LD_ERR) && t < budget) begin @(negedge HCLK); t++; end
    n_checks++;
    if (!(LD_DONE || LD_ERR)) begin
      n_fail++;
      $display("FAIL wait_end: no LD_DONE/LD_ERR within %0d cycles", budget);
    end
    t_done = cyc;
  endtask

  task automatic load_stim8();
    logic [7:0] b[8];
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(b[i]);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_htrans"}, bus.HTRANS, 2'b00);
    check({tag, "_haddr"}, bus.HADDR, BASE);
    check({tag, "_hwdata"}, bus.HWDATA, 32'h0);
    check({tag, "_hwrite"}, bus.HWRITE, 1'b0);
    check({tag, "_ready"}, LD_READY, 1'b0);
    check({tag, "_busy"}, LD_BUSY, 1'b0);
    check({tag, "_done"}, LD_DONE, 1'b0);
    check({tag, "_err"}, LD_ERR, 1'b0);
    check({tag, "_release"}, CPU_RELEASE, 1'b0);
    check({tag, "_state"}, dbg_state, S_IDLE);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int x0;
    HRESETn = 1'b0; LD_START = 1'b0; LD_LEN = '0; LD_VALID = 1'b0; LD_DATA = 8'h00;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check_reset_values("reset");
    HRESETn = 1'b1;

    // T1: two words, zero wait states, 12 cycles first byte -> LD_DONE
    load_stim8(); mem.delete(); model(2);
    do_start(2);
    send_bytes(8, 0);
    wait_end(100);
    check("t1_latency", t_done - t_first, 12);
    check("t1_done", LD_DONE, 1'b1);
    check("t1_release", CPU_RELEASE, 1'b1);
    check("t1_err", LD_ERR, 1'b0);
    check("t1_busy", LD_BUSY, 1'b0);
    check("t1_state", dbg_state, S_DONE);
    check("t1_mem0", mem.exists(32'h0) ? mem[32'h0] : 32'hDEAD_BEEF, 32'h4433_2211);
    check("t1_mem4", mem.exists(32'h4) ? mem[32'h4] : 32'hDEAD_BEEF, 32'h8877_6655);
    check("t1_queue_empty", exp_q.size(), 0);

    // T2: 3 ADDR waits, 2 DATA waits, plus a byte-stream gap
    cfg_aw = 3; cfg_dw = 2;
    mem.delete(); model(2); x0 = n_xfer;
    do_start(2);
    send_bytes(8, 3);
    wait_end(200);
    check("t2_done", LD_DONE, 1'b1);
    check("t2_xfers", n_xfer - x0, 2);
    check("t2_mem0", mem.exists(32'h0) ? mem[32'h0] : 32'hDEAD_BEEF, 32'h4433_2211);
    check("t2_mem4", mem.exists(32'h4) ? mem[32'h4] : 32'hDEAD_BEEF, 32'h8877_6655);

    // T3: two-cycle ERROR on word 1
    cfg_aw = 0; cfg_dw = 0; cfg_err_en = 1; cfg_err_two = 1; cfg_err_addr = 32'h4;
    mem.delete(); model(2);
    do_start(2);
    send_bytes(8, 0);
    wait_end(100);
    check("t3_err", LD_ERR, 1'b1);
    check("t3_done", LD_DONE, 1'b0);
    check("t3_release", CPU_RELEASE, 1'b0);
    check("t3_haddr", bus.HADDR, 32'h4);
    check("t3_state", dbg_state, S_ERR);
    check("t3_no_write4", mem.exists(32'h4), 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge HCLK);
      check("t3_htrans_idle", bus.HTRANS, 2'b00);
    end
    check("t3_queue_empty", exp_q.size(), 0);
    @(posedge HCLK); #1;

    // T5: LD_LEN = 0 from the ERR state
    LD_VALID = 1'b1; LD_DATA = 8'h5A;
    do_start(0);
    @(negedge HCLK);
    check("t5_done", LD_DONE, 1'b1);
    check("t5_err_cleared", LD_ERR, 1'b0);
    check("t5_state", dbg_state, S_DONE);
    for (int i = 0; i < 3; i++) begin
      check("t5_ready_low", LD_READY, 1'b0);
      check("t5_htrans_idle", bus.HTRANS, 2'b00);
      @(negedge HCLK);
    end
    @(posedge HCLK); #1;
    LD_VALID = 1'b0;

    // T4: single-cycle ERROR on word 2 (0x8), then a clean reload
    cfg_err_two = 0; cfg_err_addr = 32'h8;
    stim.delete();
    for (int i = 0; i < 12; i++) stim.push_back(8'h30 + 8'(i));
    mem.delete(); model(3);
    do_start(3);
    send_bytes(12, 0);
    wait_end(100);
    check("t4_err", LD_ERR, 1'b1);
    check("t4_haddr", bus.HADDR, 32'h8);
    check("t4_state", dbg_state, S_ERR);
    check("t4_mem4", mem.exists(32'h4) ? mem[32'h4] : 32'hDEAD_BEEF, 32'h3736_3534);
    cfg_err_en = 0;
    load_stim8(); mem.delete(); model(2);
    do_start(2);
    @(negedge HCLK);
    check("t4_err_cleared", LD_ERR, 1'b0);
    check("t4_haddr_base", bus.HADDR, BASE);
    @(posedge HCLK); #1;
    send_bytes(8, 0);
    wait_end(100);
    check("t4_reload_done", LD_DONE, 1'b1);
    check("t4_reload_err", LD_ERR, 1'b0);
    check("t4_reload_mem4", mem.exists(32'h4) ? mem[32'h4] : 32'hDEAD_BEEF, 32'h8877_6655);

    // T6: reset during DATA of word 3 of 8, then a full reload
    cfg_dw = 2;
    stim.delete();
    for (int i = 0; i < 32; i++) stim.push_back(8'hA0 + 8'(i));
    mem.delete(); model(8);
    do_start(8);
    send_bytes(12, 0);
    begin
      int t = 0;
      @(negedge HCLK);
      while (!(dbg_state == S_DATA && bus.HADDR == 32'h8) && t < 50) begin @(negedge HCLK); t++; end
      check("t6_reached_word3_data", {dbg_state, bus.HADDR[3:0]}, {S_DATA, 4'h8});
    end
    HRESETn = 1'b0;
    #1;
    check_reset_values("t6_async");
    exp_q.delete(); mem.delete();
    @(posedge HCLK); @(negedge HCLK);
    HRESETn = 1'b1;
    cfg_dw = 0;
    model(8);
    do_start(8);
    send_bytes(32, 0);
    wait_end(200);
    check("t6_done", LD_DONE, 1'b1);
    check("t6_mem8", mem.exists(32'h8) ? mem[32'h8] : 32'hDEAD_BEEF, 32'hABAA_A9A8);
    check("t6_mem1c", mem.exists(32'h1C) ? mem[32'h1C] : 32'hDEAD_BEEF, 32'hBFBE_BDBC);
    for (int n = 0; n < 8; n++) begin
      logic [31:0] a, w;
      a = BASE + 32'(4 * n);
      w = {stim[4*n+3], stim[4*n+2], stim[4*n+1], stim[4*n]};
      check("t6_mem", mem.exists(a) ? mem[a] : 32'hDEAD_BEEF, w);
    end
    check("t6_queue_empty", exp_q.size(), 0);

    repeat (3) @(negedge HCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
